i2c_codec_responder: RTL

I2C_CODEC_RESPONDER -- requirements
Module: i2c_codec_responder

---
 rtl/i2c_codec_responder_pkg.sv | 40 ++++
 rtl/i2c_codec_responder_line_sync.sv | 56 +++++
 rtl/i2c_codec_responder.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/i2c_codec_responder_pkg.sv
// Shared constants, FSM encoding and register default table for the I2C codec responder.
package i2c_codec_responder_pkg;

  localparam int unsigned REG_W            = 9;
  localparam int unsigned ADDR_W           = 7;
  localparam int unsigned CNT_W            = 3;
  localparam int unsigned NUM_REGS_DEFAULT = 10;

  localparam logic [ADDR_W-1:0] DEV_ADDR_DEFAULT = 7'h1A;
  localparam logic [ADDR_W-1:0] RESET_REG_ADDR   = 7'h0F;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ADDR      = 3'd1,
    ST_ACK_ADDR  = 3'd2,
    ST_BYTE1     = 3'd3,
    ST_ACK1      = 3'd4,
    ST_BYTE2     = 3'd5,
    ST_ACK2      = 3'd6,
    ST_WAIT_STOP = 3'd7
  } state_e;

  // Power-on / reset-register value of control register idx.
  function automatic logic [REG_W-1:0] reg_default(input int unsigned idx);
    logic [REG_W-1:0] val;
    case (idx)
      0:       val = 9'h097;
      1:       val = 9'h097;
      2:       val = 9'h079;
      3:       val = 9'h079;
      4:       val = 9'h00A;
      5:       val = 9'h008;
      6:       val = 9'h09F;
      7:       val = 9'h00A;
      default: val = 9'h000;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/i2c_codec_responder_line_sync.sv
// Brings sdclk/sdat into the clk domain and flags START, STOP and sdclk edges.
module i2c_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic sdclk_i,
  input  logic sdat_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);

  logic [1:0] scl_sync_q;
  logic [1:0] sda_sync_q;
  logic       scl_hist_q;
  logic       sda_hist_q;
  logic [1:0] settle_q;
  logic       armed_c;
  logic       scl_hi_c;

  // Events are suppressed until the pipeline holds only real bus samples,
  // so the reset preset of 1 cannot fake an edge or a START.
  assign armed_c  = (settle_q == 2'd3);
  assign scl_hi_c = scl_sync_q[1] & scl_hist_q;

  // Two-stage synchronizers, one history stage and registered event flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_hist_q <= 1'b1;
      sda_hist_q <= 1'b1;
      settle_q   <= '0;
      sda_o      <= 1'b1;
      scl_rise_o <= 1'b0;
      scl_fall_o <= 1'b0;
      start_o    <= 1'b0;
      stop_o     <= 1'b0;
    end else begin
      scl_sync_q <= {scl_sync_q[0], sdclk_i};
      sda_sync_q <= {sda_sync_q[0], sdat_i};
      scl_hist_q <= scl_sync_q[1];
      sda_hist_q <= sda_sync_q[1];
      if (settle_q != 2'd3) begin
        settle_q <= settle_q + 2'd1;
      end
      sda_o      <= sda_sync_q[1];
      scl_rise_o <= armed_c & scl_sync_q[1] & ~scl_hist_q;
      scl_fall_o <= armed_c & ~scl_sync_q[1] & scl_hist_q;
      start_o    <= armed_c & scl_hi_c & sda_hist_q & ~sda_sync_q[1];
      stop_o     <= armed_c & scl_hi_c & ~sda_hist_q & sda_sync_q[1];
    end
  end

endmodule

// File: rtl/i2c_codec_responder.sv
// Write-only I2C target for a codec control port: 7-bit register address, 9-bit data.
module i2c_codec_responder
  import i2c_codec_responder_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR = DEV_ADDR_DEFAULT,
  parameter int unsigned NUM_REGS = NUM_REGS_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sdclk,
  input  logic       sdat_in,
  output logic       sdat_oe,
  output logic       wr_valid,
  output logic [6:0] wr_addr,
  output logic [8:0] wr_data,
  input  logic [3:0] rd_addr,
  output logic [8:0] rd_data,
  output logic       frame_err
);

  localparam int unsigned IDX_W = $clog2(NUM_REGS);

  logic             sda;
  logic             scl_rise;
  logic             scl_fall;
  logic             start;
  logic             stop;

  state_e           state_q;
  logic [CNT_W-1:0] bit_cnt_q;
  logic [7:0]       shift_q;
  logic [7:0]       shift_d;
  logic [7:0]       byte1_q;
  logic             ack_on_q;
  logic             sdat_oe_q;
  logic             wr_valid_q;
  logic [6:0]       wr_addr_q;
  logic [8:0]       wr_data_q;
  logic             frame_err_q;
  logic [8:0]       regs_q [NUM_REGS];
  logic [8:0]       rd_data_q;
  logic             in_frame_c;

  i2c_line_sync u_line_sync (
    .clk        (clk),
    .rst        (rst),
    .sdclk_i    (sdclk),
    .sdat_i     (sdat_in),
    .sda_o      (sda),
    .scl_rise_o (scl_rise),
    .scl_fall_o (scl_fall),
    .start_o    (start),
    .stop_o     (stop)
  );

  assign shift_d    = {shift_q[6:0], sda};
  // A frame is "open" once START has been seen and before commit/reject.
  assign in_frame_c = (state_q != ST_IDLE) && (state_q != ST_WAIT_STOP);

  // Frame decoder: address match, byte capture, ACK drive and commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      byte1_q     <= '0;
      ack_on_q    <= 1'b0;
      sdat_oe_q   <= 1'b0;
      wr_valid_q  <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      frame_err_q <= 1'b0;
    end else begin
      wr_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      if (start) begin
        frame_err_q <= in_frame_c;
        state_q     <= ST_ADDR;
        bit_cnt_q   <= '0;
        ack_on_q    <= 1'b0;
        sdat_oe_q   <= 1'b0;
      end else if (stop) begin
        frame_err_q <= in_frame_c;
        state_q     <= ST_IDLE;
        bit_cnt_q   <= '0;
        ack_on_q    <= 1'b0;
        sdat_oe_q   <= 1'b0;
      end else begin
        unique case (state_q)
          ST_ADDR, ST_BYTE1, ST_BYTE2: begin
            if (scl_rise) begin
              shift_q   <= shift_d;
              bit_cnt_q <= bit_cnt_q + CNT_W'(1);
              if (bit_cnt_q == CNT_W'(7)) begin
                if (state_q == ST_ADDR) begin
                  if ((shift_d[7:1] == DEV_ADDR) && !shift_d[0]) begin
                    state_q <= ST_ACK_ADDR;
                  end else begin
                    state_q     <= ST_WAIT_STOP;
                    frame_err_q <= 1'b1;
                  end
                end else if (state_q == ST_BYTE1) begin
                  byte1_q <= shift_d;
                  state_q <= ST_ACK1;
                end else begin
                  state_q <= ST_ACK2;
                end
              end
            end
          end
          ST_ACK_ADDR, ST_ACK1, ST_ACK2: begin
            // First falling edge grabs the line, the next one lets it go.
            if (scl_fall) begin
              if (!ack_on_q) begin
                ack_on_q  <= 1'b1;
                sdat_oe_q <= 1'b1;
              end else begin
                ack_on_q  <= 1'b0;
                sdat_oe_q <= 1'b0;
                bit_cnt_q <= '0;
                if (state_q == ST_ACK_ADDR) begin
                  state_q <= ST_BYTE1;
                end else if (state_q == ST_ACK1) begin
                  state_q <= ST_BYTE2;
                end else begin
                  wr_valid_q <= 1'b1;
                  wr_addr_q  <= byte1_q[7:1];
                  wr_data_q  <= {byte1_q[0], shift_q};
                  state_q    <= ST_WAIT_STOP;
                end
              end
            end
          end
          ST_IDLE, ST_WAIT_STOP: begin
            // Only START/STOP move these states; bus traffic is ignored.
          end
          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  // Register file: applies committed writes, reset-register restore and registered read port.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs_q[IDX_W'(i)] <= reg_default(i);
      end
      rd_data_q <= '0;
    end else begin
      if (wr_valid_q) begin
        if (wr_addr_q == RESET_REG_ADDR) begin
          for (int unsigned i = 0; i < NUM_REGS; i++) begin
            regs_q[IDX_W'(i)] <= reg_default(i);
          end
        end else if (32'(wr_addr_q) < NUM_REGS) begin
          regs_q[IDX_W'(wr_addr_q)] <= wr_data_q;
        end
      end
      rd_data_q <= (32'(rd_addr) < NUM_REGS) ? regs_q[IDX_W'(rd_addr)] : '0;
    end
  end

  assign sdat_oe   = sdat_oe_q;
  assign wr_valid  = wr_valid_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign rd_data   = rd_data_q;
  assign frame_err = frame_err_q;

endmodule
